// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line (asynchronous, idle high)
//   rd_en      consumer acknowledge; clears rd_rdy and both sticky flags
//   dout       last valid byte received
//   rd_rdy     dout holds an unread byte
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: an unread byte was overwritten
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       rd_rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  logic [7:0]       dout_q, dout_d;
  logic             rd_rdy_q, rd_rdy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      dout_q      <= '0;
      rd_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      dout_q      <= dout_d;
      rd_rdy_q    <= rd_rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, bit timing and consumer handshake
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    dout_d      = dout_q;
    rd_rdy_d    = rd_rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    // Consumer clears come first so a same-cycle set below wins.
    if (rd_en) begin
      rd_rdy_d    = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check mid start bit; a high line here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d  = S_IDLE;
            dout_d   = shift_q;
            rd_rdy_d = 1'b1;
            // A read in the same cycle consumes the old byte: no overrun.
            if (rd_rdy_q && !rd_en) begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = S_BRK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BRK: begin
        // Hold off until the line returns high so a break flags only once.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign rd_rdy    = rd_rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
